// File: rtl/trivium_stream.sv
// Trivium stream cipher engine: loads KEY/IV on START, runs the warm-up rounds,
// then XORs each accepted DIN byte with 8 fresh keystream bits (LSB first).
module trivium_stream #(
   parameter int unsigned INIT_ROUNDS = 1152
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        START,
   input  logic [79:0] KEY,
   input  logic [79:0] IV,
   input  logic [7:0]  DIN,
   input  logic        DIN_VALID,
   output logic        DIN_READY,
   output logic [7:0]  DOUT,
   output logic        DOUT_VALID,
   input  logic        DOUT_READY,
   output logic        KS_READY
);

   localparam int unsigned      CNT_W      = $clog2(INIT_ROUNDS + 1);
   localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(INIT_ROUNDS - 1);

   typedef enum logic [1:0] {IDLE, WARMUP, RUN, GEN} state_e;

   state_e           state_q;
   logic [287:0]     s_q;
   logic [CNT_W-1:0] round_q;
   logic [2:0]       bit_q;
   logic [7:0]       din_q;
   logic [6:0]       ks_q;
   logic [7:0]       dout_q;
   logic             dout_valid_q;
   logic             ks_ready_q;

   logic [287:0] s_load;
   logic [287:0] s_step;
   logic         t1, t2, t3, z;
   logic         accept;

   assign s_load = {3'b111, 112'd0, IV, 13'd0, KEY};

   assign t1 = s_q[65]  ^ (s_q[90]  & s_q[91])  ^ s_q[92]  ^ s_q[170];
   assign t2 = s_q[161] ^ (s_q[174] & s_q[175]) ^ s_q[176] ^ s_q[263];
   assign t3 = s_q[242] ^ (s_q[285] & s_q[286]) ^ s_q[287] ^ s_q[68];
   assign z  = s_q[65] ^ s_q[92] ^ s_q[161] ^ s_q[176] ^ s_q[242] ^ s_q[287];

   // Each of the three sub-registers shifts up by one, fed by another's feedback.
   assign s_step = {s_q[286:177], t2, s_q[175:93], t1, s_q[91:0], t3};

   assign DIN_READY  = (state_q == RUN) && !START && (!dout_valid_q || DOUT_READY);
   assign accept     = DIN_VALID && DIN_READY;
   assign DOUT       = dout_q;
   assign DOUT_VALID = dout_valid_q;
   assign KS_READY   = ks_ready_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, regardless of statement order.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         // NOTE: the datapath registers are reset too; this block has no
         // memory array, so nothing is exempt from reset.
         state_q      <= IDLE;
         s_q          <= '0;
         round_q      <= '0;
         bit_q        <= '0;
         din_q        <= '0;
         ks_q         <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         ks_ready_q   <= 1'b0;
      end else if (START) begin
         state_q      <= WARMUP;
         s_q          <= s_load;
         round_q      <= '0;
         bit_q        <= '0;
         dout_valid_q <= 1'b0;
         ks_ready_q   <= 1'b0;
      end else begin
         if (dout_valid_q && DOUT_READY) begin
            dout_valid_q <= 1'b0;
         end
         unique case (state_q)
            IDLE: begin
            end
            WARMUP: begin
               s_q     <= s_step;
               round_q <= round_q + 1'b1;
               if (round_q == LAST_ROUND) begin
                  state_q <= RUN;
               end
            end
            RUN: begin
               ks_ready_q <= 1'b1;
               if (accept) begin
                  din_q   <= DIN;
                  bit_q   <= '0;
                  state_q <= GEN;
               end
            end
            GEN: begin
               s_q   <= s_step;
               ks_q  <= {z, ks_q[6:1]};
               bit_q <= bit_q + 3'd1;
               // The eighth bit goes straight into the result; the first seven sit in ks_q.
               if (bit_q == 3'd7) begin
                  dout_q       <= din_q ^ {z, ks_q};
                  dout_valid_q <= 1'b1;
                  state_q      <= RUN;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trivium_stream.sv
// Self-checking bench for trivium_stream: table-driven vectors, random traffic
// and hand-written corner sequences against a bit-array model of the cipher.
module tb_trivium_stream;

   localparam int INIT_ROUNDS = 1152;

   logic        CLK = 1'b0;
   logic        RST;
   logic        START;
   logic [79:0] KEY;
   logic [79:0] IV;
   logic [7:0]  DIN;
   logic        DIN_VALID;
   logic        DIN_READY;
   logic [7:0]  DOUT;
   logic        DOUT_VALID;
   logic        DOUT_READY;
   logic        KS_READY;

   trivium_stream #(.INIT_ROUNDS(INIT_ROUNDS)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .START      (START),
      .KEY        (KEY),
      .IV         (IV),
      .DIN        (DIN),
      .DIN_VALID  (DIN_VALID),
      .DIN_READY  (DIN_READY),
      .DOUT       (DOUT),
      .DOUT_VALID (DOUT_VALID),
      .DOUT_READY (DOUT_READY),
      .KS_READY   (KS_READY)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [79:0] key;
      logic [79:0] iv;
      logic [31:0] din;
      logic [31:0] exp;
   } vec_t;

   // Reference model: the 288 state bits as a plain array, S[0] first.
   bit ms [288];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [79:0] rand80();
      return {16'($urandom), $urandom, $urandom};
   endfunction

   function automatic void model_load(input logic [79:0] k, input logic [79:0] v);
      for (int i = 0; i < 288; i++) ms[i] = 1'b0;
      for (int i = 0; i < 80; i++) begin
         ms[i]      = k[i];
         ms[93 + i] = v[i];
      end
      ms[285] = 1'b1;
      ms[286] = 1'b1;
      ms[287] = 1'b1;
   endfunction

   function automatic bit model_step();
      bit a, b, c, z;
      z = ms[65] ^ ms[92] ^ ms[161] ^ ms[176] ^ ms[242] ^ ms[287];
      a = ms[65]  ^ (ms[90]  & ms[91])  ^ ms[92]  ^ ms[170];
      b = ms[161] ^ (ms[174] & ms[175]) ^ ms[176] ^ ms[263];
      c = ms[242] ^ (ms[285] & ms[286]) ^ ms[287] ^ ms[68];
      for (int i = 287; i > 177; i--) ms[i] = ms[i - 1];
      ms[177] = b;
      for (int i = 176; i > 93; i--) ms[i] = ms[i - 1];
      ms[93] = a;
      for (int i = 92; i > 0; i--) ms[i] = ms[i - 1];
      ms[0] = c;
      return z;
   endfunction

   function automatic logic [7:0] model_byte();
      logic [7:0] b;
      for (int k = 0; k < 8; k++) b[k] = model_step();
      return b;
   endfunction

   function automatic void model_warmup();
      for (int i = 0; i < INIT_ROUNDS; i++) void'(model_step());
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Called 1 time unit after an edge; the next edge is the START edge.
   task automatic do_start(input logic [79:0] k, input logic [79:0] v);
      int cyc;
      bit saw_valid;
      KEY   = k;
      IV    = v;
      START = 1'b1;
      #1;
      check("din_ready_under_start", 64'(DIN_READY), 64'd0);
      @(posedge CLK);
      #1;
      START     = 1'b0;
      DIN_VALID = 1'b0;
      model_load(k, v);
      model_warmup();
      cyc       = 0;
      saw_valid = 1'b0;
      while (!KS_READY && cyc < 2 * INIT_ROUNDS) begin
         @(posedge CLK);
         #1;
         cyc++;
         if (DOUT_VALID) saw_valid = 1'b1;
      end
      check("ks_ready_latency", 64'(cyc), 64'(INIT_ROUNDS + 1));
      check("no_dout_in_warmup", 64'(saw_valid), 64'd0);
   endtask

   task automatic accept_byte(input logic [7:0] d);
      int w;
      w         = 0;
      DIN       = d;
      DIN_VALID = 1'b1;
      #1;
      while (!DIN_READY && w < 50) begin
         @(posedge CLK);
         #2;
         w++;
      end
      check("din_ready_seen", 64'(DIN_READY), 64'd1);
      @(posedge CLK);
      #1;
      DIN_VALID = 1'b0;
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      while (!DOUT_VALID && lat < 20) begin
         @(posedge CLK);
         #1;
         lat++;
      end
   endtask

   task automatic xfer(input logic [7:0] d, output logic [7:0] q);
      int lat;
      logic [7:0] exp;
      exp = d ^ model_byte();
      accept_byte(d);
      wait_result(lat);
      check("latency", 64'(lat), 64'd8);
      check("dout", 64'(DOUT), 64'(exp));
      q          = DOUT;
      DOUT_READY = 1'b1;
      tick();
      DOUT_READY = 1'b0;
      check("dout_valid_clear", 64'(DOUT_VALID), 64'd0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs [4];
      logic [7:0]  q;
      logic [79:0] k, v;
      logic [7:0]  pt [16];
      logic [7:0]  ct [16];
      logic [7:0]  sb [5];
      logic [7:0]  sexp [5];
      logic [7:0]  souts [5];
      int          acc [5];
      int          res [5];
      int          na, nr, cyc, lat, bad;
      bit          will;
      logic [7:0]  d0, d1, e0, e1;

      RST = 1'b1; START = 1'b0; KEY = '0; IV = '0;
      DIN = '0; DIN_VALID = 1'b0; DOUT_READY = 1'b0;

      vecs[0] = '{key: 80'h0, iv: 80'h0, din: 32'h0, exp: 32'h0};
      vecs[1] = '{key: '1, iv: '1, din: 32'hffff_ffff, exp: 32'h0};
      vecs[2] = '{key: rand80(), iv: rand80(), din: $urandom, exp: 32'h0};
      vecs[3] = '{key: 80'h0123_4567_89ab_cdef_0011, iv: rand80(), din: $urandom, exp: 32'h0};
      for (int i = 0; i < 4; i++) begin
         model_load(vecs[i].key, vecs[i].iv);
         model_warmup();
         for (int b = 0; b < 4; b++)
            vecs[i].exp[8*b +: 8] = vecs[i].din[8*b +: 8] ^ model_byte();
      end

      // Reset state, held and then released.
      repeat (3) @(posedge CLK);
      #1;
      check("rst_dout", 64'(DOUT), 64'd0);
      check("rst_dout_valid", 64'(DOUT_VALID), 64'd0);
      check("rst_ks_ready", 64'(KS_READY), 64'd0);
      check("rst_din_ready", 64'(DIN_READY), 64'd0);
      RST = 1'b0;
      repeat (3) tick();
      DIN_VALID = 1'b1;
      #1;
      check("idle_din_ready", 64'(DIN_READY), 64'd0);
      check("idle_ks_ready", 64'(KS_READY), 64'd0);
      DIN_VALID = 1'b0;
      tick();

      // Table-driven vectors.
      for (int i = 0; i < 4; i++) begin
         do_start(vecs[i].key, vecs[i].iv);
         for (int b = 0; b < 4; b++) begin
            xfer(vecs[i].din[8*b +: 8], q);
            check("vec_dout", 64'(q), 64'(vecs[i].exp[8*b +: 8]));
         end
      end

      // All-zero key/IV: 64 keystream bytes.
      do_start(80'h0, 80'h0);
      for (int i = 0; i < 64; i++) xfer(8'h00, q);

      // Round trip; the restart coincides with a pending DIN_VALID.
      k = rand80();
      v = rand80();
      do_start(k, v);
      for (int i = 0; i < 16; i++) begin
         pt[i] = 8'($urandom);
         xfer(pt[i], ct[i]);
      end
      DIN       = 8'h5a;
      DIN_VALID = 1'b1;
      do_start(k, v);
      for (int i = 0; i < 16; i++) begin
         xfer(ct[i], q);
         check("roundtrip", 64'(q), 64'(pt[i]));
      end

      // Back-to-back streaming with DOUT_READY held high.
      do_start(rand80(), rand80());
      for (int i = 0; i < 5; i++) begin
         sb[i]   = 8'($urandom);
         sexp[i] = sb[i] ^ model_byte();
         acc[i]  = 0;
         res[i]  = 0;
         souts[i] = '0;
      end
      DOUT_READY = 1'b1;
      DIN        = sb[0];
      DIN_VALID  = 1'b1;
      na = 0; nr = 0; cyc = 0;
      while (nr < 5 && cyc < 200) begin
         #1;
         will = DIN_READY && DIN_VALID;
         @(posedge CLK);
         #1;
         cyc++;
         if (will) begin
            acc[na] = cyc;
            na++;
            if (na < 5) DIN = sb[na];
            else DIN_VALID = 1'b0;
         end
         if (DOUT_VALID) begin
            if (nr < 5) begin
               res[nr]   = cyc;
               souts[nr] = DOUT;
            end
            nr++;
         end
      end
      DOUT_READY = 1'b0;
      DIN_VALID  = 1'b0;
      check("stream_count", 64'(nr), 64'd5);
      for (int i = 0; i < 5; i++) begin
         check("stream_latency", 64'(res[i] - acc[i]), 64'd8);
         check("stream_dout", 64'(souts[i]), 64'(sexp[i]));
         if (i > 0) check("stream_gap", 64'(acc[i] - acc[i-1]), 64'd9);
      end
      tick();

      // Output stall for 20 cycles, then seamless continuation.
      do_start(rand80(), rand80());
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      e0 = d0 ^ model_byte();
      e1 = d1 ^ model_byte();
      accept_byte(d0);
      wait_result(lat);
      check("stall_first_latency", 64'(lat), 64'd8);
      check("stall_first_dout", 64'(DOUT), 64'(e0));
      DIN       = d1;
      DIN_VALID = 1'b1;
      bad       = 0;
      repeat (20) begin
         #1;
         if (DOUT !== e0 || DOUT_VALID !== 1'b1 || DIN_READY !== 1'b0) bad++;
         @(posedge CLK);
         #1;
      end
      check("stall_hold", 64'(bad), 64'd0);
      DOUT_READY = 1'b1;
      #1;
      check("stall_release_ready", 64'(DIN_READY), 64'd1);
      @(posedge CLK);
      #1;
      DOUT_READY = 1'b0;
      DIN_VALID  = 1'b0;
      check("stall_release_clear", 64'(DOUT_VALID), 64'd0);
      wait_result(lat);
      check("stall_next_latency", 64'(lat), 64'd8);
      check("stall_next_dout", 64'(DOUT), 64'(e1));
      DOUT_READY = 1'b1;
      tick();
      DOUT_READY = 1'b0;

      // START at the fourth keystream edge of an in-flight byte.
      do_start(rand80(), rand80());
      accept_byte(8'($urandom));
      repeat (3) tick();
      check("gen_no_dout_yet", 64'(DOUT_VALID), 64'd0);
      do_start(rand80(), rand80());
      for (int i = 0; i < 4; i++) xfer(8'($urandom), q);

      // Asynchronous reset around warm-up round 500.
      KEY   = rand80();
      IV    = rand80();
      START = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
      repeat (499) @(posedge CLK);
      #3;
      RST = 1'b1;
      #1;
      check("async_rst_dout", 64'(DOUT), 64'd0);
      check("async_rst_dout_valid", 64'(DOUT_VALID), 64'd0);
      check("async_rst_ks_ready", 64'(KS_READY), 64'd0);
      check("async_rst_din_ready", 64'(DIN_READY), 64'd0);
      #2;
      RST       = 1'b0;
      DIN_VALID = 1'b1;
      bad       = 0;
      repeat (5) begin
         tick();
         #1;
         if (KS_READY !== 1'b0 || DIN_READY !== 1'b0 || DOUT_VALID !== 1'b0) bad++;
      end
      check("post_rst_idle", 64'(bad), 64'd0);
      DIN_VALID = 1'b0;
      tick();
      do_start(rand80(), rand80());
      for (int i = 0; i < 4; i++) xfer(8'($urandom), q);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/trivium_stream.md
TRIVIUM_STREAM -- requirements
Module: trivium_stream

Interface
REQ-001: Parameter INIT_ROUNDS, default 1152, is the number of warm-up state updates after load (4 x 288).
REQ-002: CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003: RST  input  1  asynchronous, active-high reset.
REQ-004: START  input  1  single-cycle pulse; loads KEY/IV and begins warm-up.
REQ-005: KEY  input  80  cipher key; sampled only in the START cycle.
REQ-006: IV  input  80  initialisation vector; sampled only in the START cycle.
REQ-007: DIN  input  8  plaintext/ciphertext byte.
REQ-008: DIN_VALID  input  1  DIN holds a byte.
REQ-009: DIN_READY  output  1  block accepts DIN this cycle.
REQ-010: DOUT  output  8  DIN XOR keystream byte.
REQ-011: DOUT_VALID  output  1  DOUT holds a result.
REQ-012: DOUT_READY  input  1  consumer takes DOUT this cycle.
REQ-013: KS_READY  output  1  warm-up complete, keystream available.

Function
REQ-014: Internal state S[287:0]; load on START edge: S[79:0]=KEY, S[92:80]=0, S[172:93]=IV, S[284:173]=0, S[287:285]=3'b111.
REQ-015: One update: t1=S[65]^(S[90]&S[91])^S[92]^S[170]; t2=S[161]^(S[174]&S[175])^S[176]^S[263]; t3=S[242]^(S[285]&S[286])^S[287]^S[68].
REQ-016: Update shift: S[92:0]<={S[91:0],t3}; S[176:93]<={S[175:93],t1}; S[287:177]<={S[286:177],t2}.
REQ-017: Keystream bit z=S[65]^S[92]^S[161]^S[176]^S[242]^S[287], taken from S before the update in the same cycle.
REQ-018: FSM states IDLE, WARMUP, RUN, GEN; reset state IDLE.
REQ-019: IDLE: S holds; START -> load, WARMUP, round counter=0.
REQ-020: WARMUP: one update per cycle, z discarded; after the INIT_ROUNDS-th update -> RUN, KS_READY=1 from the next cycle.
REQ-021: RUN: S holds; DIN_READY = RUN & !START & (!DOUT_VALID | DOUT_READY).
REQ-022: Acceptance = DIN_VALID & DIN_READY at edge E0; DIN captured, state -> GEN.
REQ-023: GEN: updates at edges E1..E8; z at edge Ek written to keystream bit k-1 (LSB first).
REQ-024: At E8, DOUT <= captured DIN ^ keystream byte; DOUT_VALID=1; state -> RUN.
REQ-025: Latency: DOUT_VALID high 8 edges after acceptance; maximum throughput 1 byte per 9 cycles.
REQ-026: DOUT/DOUT_VALID hold until DOUT_READY & DOUT_VALID at an edge; DOUT_VALID then clears unless a new result completes at that edge.
REQ-027: DIN_READY low in IDLE, WARMUP, GEN, and whenever START is high.
REQ-028: Encryption and decryption are identical: the same KEY/IV and byte order return the original data.
REQ-029: START in any state (incl. WARMUP, GEN): reload, restart warm-up, KS_READY=0, DOUT_VALID=0, the in-flight byte is discarded.
REQ-030: START coincident with DIN_VALID: START wins, byte not accepted.
REQ-031: Round counter width >= clog2(INIT_ROUNDS+1); no wrap inside warm-up.
REQ-032: Keystream does not advance in RUN while idle or stalled on DOUT_READY.

Reset
REQ-033: RST high asynchronously forces IDLE, S=0, round counter=0, DOUT=0, DOUT_VALID=0, KS_READY=0, DIN_READY=0.
REQ-034: After RST deasserts, the block stays in IDLE until START; mid-operation reset discards all state.

Verification
REQ-035: KEY=0, IV=0, START -> KS_READY rises exactly 1153 cycles after the START edge; the first 64 DOUT bytes with DIN=0 match a bit-accurate model of REQ-014..017.
REQ-036: Random KEY/IV, encrypt 16 bytes, restart with the same KEY/IV and feed the ciphertext -> the original 16 bytes return.
REQ-037: DIN_VALID held high, DOUT_READY=1 -> DOUT_VALID at E0+8; next acceptance every 9 cycles.
REQ-038: DOUT_READY=0 for 20 cycles after a result -> DOUT stable, DIN_READY=0, S unchanged; release -> the next byte continues the keystream seamlessly.
REQ-039: START at GEN edge E4 -> DOUT_VALID never asserts for that byte, warm-up restarts, and the new keystream matches the model for the new KEY/IV.
REQ-040: RST pulse during WARMUP round 500 -> outputs zero immediately (asynchronously); a subsequent START gives a normal 1152-round warm-up.
